h264chroma_ctrl: RTL and testbench
==================================

# h264chroma_ctrl

Sequencer for the 8x8 chroma intra/DC prediction core. It receives a slice start command and the picture dimensions in macroblocks, and pulls packed chroma words from an upstream valid/ready stream: 32 words per macroblock, 16 Cb then 16 Cr. It drives the core's NEWSLICE/NEWLINE/STROBEI/DATAI inputs under the core's READYI flow control. It tracks in-flight macroblocks through the core's XXINC completion pulse, so a line is never restarted while the core still holds data.

## Interface
Parameters:
- MBCNT_W, 8, width of macroblock column/row counters and dimension inputs
- MAXINFLIGHT, 2, macroblocks the core may hold (one processing, one loaded)

Ports:
- CLK2  in  1  single clock, all logic on rising edge
- RST_N  in  1  reset, synchronous, active-high (named as in the rest of the codebase)
- START  in  1  one-cycle slice start, ignored while BUSY
- MBW  in  MBCNT_W  macroblocks per line, sampled on accepted START
- MBH  in  MBCNT_W  lines per slice, sampled on accepted START
- SRCVALID  in  1  upstream word valid
- SRCDATA  in  32  upstream chroma word (4 pixels)
- SRCREADY  out  1  upstream word accepted when SRCVALID&&SRCREADY
- READYI  in  1  core can accept words
- XXINC  in  1  core finished one macroblock (one-cycle pulse)
- NEWSLICE  out  1  to core, registered
- NEWLINE  out  1  to core, registered
- STROBEI  out  1  to core, registered word strobe
- DATAI  out  32  to core, registered word
- BUSY  out  1  slice in progress
- DONE  out  1  one-cycle pulse at slice end
- ERR  out  1  sticky protocol error, cleared by reset or accepted START
- MBX  out  MBCNT_W  column of macroblock being loaded
- MBY  out  MBCNT_W  current line

## Operation
- States: IDLE, LINE, LOAD, DRAIN, FIN.
- IDLE:
  - START latches MBW/MBH, clears MBX, MBY and ERR.
  - If MBW==0 or MBH==0, go to FIN; otherwise go to LINE.
- LINE: lasts one cycle, then LOAD.
  - Clears MBX, the word counter wcnt and the bubble flag.
  - The next cycle carries NEWLINE=1, plus NEWSLICE=1 if MBY==0. On the first line both pulses are in the same cycle.
- LOAD:
  - SRCREADY = READYI && !bubble && (state==LOAD).
  - On handshake, DATAI<=SRCDATA and STROBEI<=1, and wcnt (5 bits) increments.
  - When wcnt goes 15->16 or 31->0, bubble is set for exactly one cycle.
  - On word 31: inflight++, then either MBX++ or, if MBX==MBW-1, go to DRAIN with MBX held.
- DRAIN: wait until inflight==0. Then if MBY==MBH-1 go to FIN; else MBY++ and go to LINE.
- FIN: DONE<=1 for one cycle, then IDLE.
- inflight counter (2 bits):
  - +1 on MB load completion, -1 on XXINC; both in the same cycle leaves it unchanged.
  - XXINC with inflight==0 sets ERR and is ignored.
  - An increment that would exceed MAXINFLIGHT sets ERR and saturates.
- BUSY = state!=IDLE. START while BUSY has no effect.

## Timing
- Reset values: SRCREADY, NEWSLICE, NEWLINE, STROBEI, BUSY, DONE and ERR are 0; DATAI, MBX and MBY are 0.
- Reset mid-slice returns to IDLE in the next cycle. No NEWLINE is emitted; the core is reset by the same RST_N.
- Word latency: handshake in cycle t gives STROBEI/DATAI in cycle t+1.
- The bubble cycle exists because the core's READYI reflects a 16-word boundary only from t+2.
- Peak rate: 16 words, 1 idle, 16 words, 1 idle per macroblock.
- START accepted in cycle t:
  - LINE in t+1.
  - NEWLINE/NEWSLICE in t+2; the first SRCREADY can also assert in t+2.
- DRAIN exit with inflight==0 in cycle t: DONE in t+2 (via FIN), or NEWLINE in t+2 (via LINE).
- Empty slice: START in t gives DONE in t+2.
- No STROBEI occurs in the cycle NEWLINE is high.

## Structure
- h264chroma_pkg holds:
  - state enum {IDLE, LINE, LOAD, DRAIN, FIN}
  - WORDS_PER_MB=32 and WORDS_PER_HALF=16
- No sub-module. A single module of about 150-250 lines with one FSM and counters.

## Test plan
- MBW=2, MBH=1, SRCVALID=1, behavioural core model:
  - START gives NEWSLICE&NEWLINE together.
  - 64 STROBEI pulses with DATAI equal to the source words in order.
  - DRAIN holds until the 2nd XXINC, then DONE; ERR=0.
- READYI=1, SRCVALID=1 throughout: STROBEI pattern is 16 high, 1 low, 16 high, 1 low per MB.
- READYI dropped for 5 cycles at word 20: no SRCREADY or STROBEI during the drop; resumes with word 20; still 32 words per MB.
- MBW=1, MBH=2, with XXINC delayed 40 cycles:
  - Second NEWLINE occurs exactly 2 cycles after the XXINC, with NEWSLICE=0.
  - MBY=1 during the second line.
- START with MBW=0: DONE 2 cycles later, no NEWLINE or STROBEI; START while BUSY is ignored.
- Error and reset cases:
  - XXINC injected while inflight==0 sets ERR=1, and ERR stays 1.
  - RST_N asserted mid-LOAD clears all outputs to their reset values in the next cycle.

Source files
------------

// File: rtl/h264chroma_pkg.sv
// Shared types and constants for the chroma prediction sequencer.
package h264chroma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LINE,
        LOAD,
        DRAIN,
        FIN
    } state_e;

    localparam int WORDS_PER_MB   = 32;
    localparam int WORDS_PER_HALF = 16;

endpackage

// File: rtl/h264chroma_ctrl.sv
// Slice sequencer feeding 32-word chroma macroblocks into the 8x8 prediction core,
// pacing line restarts on the core's per-macroblock completion pulse.
module h264chroma_ctrl
    import h264chroma_pkg::*;
#(
    parameter int MBCNT_W     = 8,
    parameter int MAXINFLIGHT = 2
) (
    input  logic               CLK2,
    input  logic               RST_N,
    input  logic               START,
    input  logic [MBCNT_W-1:0] MBW,
    input  logic [MBCNT_W-1:0] MBH,
    input  logic               SRCVALID,
    input  logic [31:0]        SRCDATA,
    output logic               SRCREADY,
    input  logic               READYI,
    input  logic               XXINC,
    output logic               NEWSLICE,
    output logic               NEWLINE,
    output logic               STROBEI,
    output logic [31:0]        DATAI,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [MBCNT_W-1:0] MBX,
    output logic [MBCNT_W-1:0] MBY
);

    localparam logic [4:0] HALF_LAST    = 5'(WORDS_PER_HALF - 1);
    localparam logic [4:0] MB_LAST      = 5'(WORDS_PER_MB - 1);
    localparam logic [1:0] INFLIGHT_MAX = 2'(MAXINFLIGHT);

    state_e             state;
    logic [MBCNT_W-1:0] mbw_q;
    logic [MBCNT_W-1:0] mbh_q;
    logic [4:0]         wcnt;
    logic               bubble;
    logic [1:0]         inflight;
    logic [1:0]         inflight_nxt;
    logic               err_set;
    logic               handshake;
    logic               mb_loaded;
    logic               last_col;
    logic               last_row;

    // The bubble covers the cycle where the core's READYI still lags a half-MB boundary.
    assign SRCREADY  = READYI && !bubble && (state == LOAD);
    assign BUSY      = (state != IDLE);
    assign handshake = SRCVALID && SRCREADY;
    assign mb_loaded = handshake && (wcnt == MB_LAST);
    assign last_col  = (MBX == mbw_q - MBCNT_W'(1));
    assign last_row  = (MBY == mbh_q - MBCNT_W'(1));

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        inflight_nxt = inflight;
        err_set      = 1'b0;
        case ({mb_loaded, XXINC})
            2'b10: begin
                if (inflight >= INFLIGHT_MAX) err_set = 1'b1;
                else                          inflight_nxt = inflight + 2'd1;
            end
            2'b01: begin
                if (inflight == 2'd0) err_set = 1'b1;
                else                  inflight_nxt = inflight - 2'd1;
            end
            2'b11: begin
                // A spurious completion is dropped; the load still counts.
                if (inflight == 2'd0) begin
                    err_set      = 1'b1;
                    inflight_nxt = 2'd1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state and counters use non-blocking assignments; later ones in the block win.
    always_ff @(posedge CLK2) begin
        if (RST_N) begin
            state    <= IDLE;
            mbw_q    <= '0;
            mbh_q    <= '0;
            wcnt     <= '0;
            bubble   <= 1'b0;
            inflight <= '0;
            NEWSLICE <= 1'b0;
            NEWLINE  <= 1'b0;
            STROBEI  <= 1'b0;
            DATAI    <= '0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            MBX      <= '0;
            MBY      <= '0;
        end else begin
            NEWSLICE <= 1'b0;
            NEWLINE  <= 1'b0;
            STROBEI  <= 1'b0;
            DONE     <= 1'b0;
            inflight <= inflight_nxt;
            bubble   <= handshake && ((wcnt == HALF_LAST) || (wcnt == MB_LAST));
            if (err_set) ERR <= 1'b1;

            if (handshake) begin
                DATAI   <= SRCDATA;
                STROBEI <= 1'b1;
                wcnt    <= wcnt + 5'd1;
            end

            case (state)
                IDLE: begin
                    if (START) begin
                        mbw_q <= MBW;
                        mbh_q <= MBH;
                        MBX   <= '0;
                        MBY   <= '0;
                        ERR   <= err_set;
                        state <= ((MBW == '0) || (MBH == '0)) ? FIN : LINE;
                    end
                end
                LINE: begin
                    MBX      <= '0;
                    wcnt     <= '0;
                    bubble   <= 1'b0;
                    NEWLINE  <= 1'b1;
                    NEWSLICE <= (MBY == '0);
                    state    <= LOAD;
                end
                LOAD: begin
                    if (mb_loaded) begin
                        if (last_col) state <= DRAIN;
                        else          MBX   <= MBX + MBCNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Leaving on the post-update count lets a line restart two cycles after XXINC.
                    if (inflight_nxt == 2'd0) begin
                        if (last_row) begin
                            state <= FIN;
                        end else begin
                            MBY   <= MBY + MBCNT_W'(1);
                            state <= LINE;
                        end
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_h264chroma_ctrl.sv
// Scoreboard bench for h264chroma_ctrl: a source model, a behavioural core model and a
// negedge monitor that pops expected words whenever the sequencer strobes the core.
module tb_h264chroma_ctrl;

    localparam int MBCNT_W = 8;

    logic               CLK2     = 1'b0;
    logic               RST_N    = 1'b1;
    logic               START    = 1'b0;
    logic [MBCNT_W-1:0] MBW      = '0;
    logic [MBCNT_W-1:0] MBH      = '0;
    logic               SRCVALID = 1'b0;
    logic [31:0]        SRCDATA;
    logic               READYI   = 1'b0;
    logic               XXINC    = 1'b0;
    logic               SRCREADY;
    logic               NEWSLICE;
    logic               NEWLINE;
    logic               STROBEI;
    logic [31:0]        DATAI;
    logic               BUSY;
    logic               DONE;
    logic               ERR;
    logic [MBCNT_W-1:0] MBX;
    logic [MBCNT_W-1:0] MBY;

    h264chroma_ctrl #(.MBCNT_W(MBCNT_W), .MAXINFLIGHT(2)) dut (
        .CLK2     (CLK2),
        .RST_N    (RST_N),
        .START    (START),
        .MBW      (MBW),
        .MBH      (MBH),
        .SRCVALID (SRCVALID),
        .SRCDATA  (SRCDATA),
        .SRCREADY (SRCREADY),
        .READYI   (READYI),
        .XXINC    (XXINC),
        .NEWSLICE (NEWSLICE),
        .NEWLINE  (NEWLINE),
        .STROBEI  (STROBEI),
        .DATAI    (DATAI),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .MBX      (MBX),
        .MBY      (MBY)
    );

    always #5 CLK2 = ~CLK2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t           exp_q[$];
    int             xx_q[$];
    int             nl_cyc[$];
    int             done_cyc[$];
    int             xx_cyc[$];
    int             strobe_cyc[$];
    logic           ns_at_nl[$];
    logic [7:0]     mby_at_nl[$];
    int             cyc       = 0;
    int             hs_cnt    = 0;
    int             mb_words  = 0;
    int             src_idx   = 0;
    int             xx_delay  = 40;
    logic           clear_req = 1'b0;
    logic           inject_xx = 1'b0;
    int             pass_cnt  = 0;
    int             chk_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mk_word(input int i);
        return {8'hC0, 8'(i), ~8'(i), 8'(i * 3)};
    endfunction

    // Cycle index: stable between edges, read by every other process.
    always @(posedge CLK2) cyc <= cyc + 1;

    // Source: each accepted word becomes the expected core word one cycle later.
    initial begin : source
        logic took;
        SRCDATA = mk_word(0);
        forever begin
            @(negedge CLK2);
            if (clear_req) exp_q.delete();
            took = SRCVALID && SRCREADY;
            if (took) exp_q.push_back('{data: SRCDATA, due: cyc + 1});
            @(posedge CLK2); #1;
            if (took) begin
                src_idx++;
                SRCDATA = mk_word(src_idx);
            end
        end
    end

    // Core model: one XXINC a fixed delay after each 32nd strobe, plus injected pulses.
    initial begin : core_model
        forever begin
            @(posedge CLK2); #1;
            if (clear_req) begin
                xx_q.delete();
                mb_words = 0;
            end
            if (STROBEI) begin
                mb_words++;
                if (mb_words == 32) begin
                    mb_words = 0;
                    xx_q.push_back(cyc + xx_delay);
                end
            end
            XXINC = inject_xx;
            if (!inject_xx && xx_q.size() > 0 && xx_q[0] <= cyc) begin
                void'(xx_q.pop_front());
                XXINC = 1'b1;
            end
        end
    end

    // Monitor: compares strobed words against the scoreboard and logs control events.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK2);
            if (clear_req) begin
                nl_cyc.delete();
                done_cyc.delete();
                xx_cyc.delete();
                strobe_cyc.delete();
                ns_at_nl.delete();
                mby_at_nl.delete();
                hs_cnt = 0;
            end
            if (SRCVALID && SRCREADY) hs_cnt++;
            if (STROBEI) begin
                strobe_cyc.push_back(cyc);
                check("strobe_has_expected_word", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("datai", DATAI, e.data);
                    check("strobe_latency", cyc, e.due);
                end
            end
            if (NEWLINE) begin
                nl_cyc.push_back(cyc);
                ns_at_nl.push_back(NEWSLICE);
                mby_at_nl.push_back(MBY);
                check("no_strobe_with_newline", 32'(STROBEI), 0);
            end
            if (DONE)  done_cyc.push_back(cyc);
            if (XXINC) xx_cyc.push_back(cyc);
        end
    end

    task automatic clear_logs();
        @(posedge CLK2); #1;
        clear_req = 1'b1;
        repeat (2) begin
            @(posedge CLK2); #1;
        end
        clear_req = 1'b0;
    endtask

    task automatic start_slice(input logic [7:0] w, input logic [7:0] h, output int t);
        @(posedge CLK2); #1;
        MBW   = w;
        MBH   = h;
        START = 1'b1;
        t     = cyc;
        @(posedge CLK2); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        while (done_cyc.size() == 0 && g < budget) begin
            @(posedge CLK2); #1;
            g++;
        end
        check("done_within_budget", 32'(done_cyc.size()), 1);
    endtask

    task automatic wait_hs(input int n, input int budget);
        int g = 0;
        while (hs_cnt < n && g < budget) begin
            @(posedge CLK2); #1;
            g++;
        end
        check("handshakes_within_budget", 32'(hs_cnt), 32'(n));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        int c;
        repeat (3) @(posedge CLK2);
        #1;
        RST_N    = 1'b0;
        SRCVALID = 1'b1;
        READYI   = 1'b1;

        // Reset state
        @(negedge CLK2);
        check("rst_srcready", 32'(SRCREADY), 0);
        check("rst_newslice", 32'(NEWSLICE), 0);
        check("rst_newline",  32'(NEWLINE),  0);
        check("rst_strobei",  32'(STROBEI),  0);
        check("rst_busy",     32'(BUSY),     0);
        check("rst_done",     32'(DONE),     0);
        check("rst_err",      32'(ERR),      0);
        check("rst_datai",    DATAI,         0);
        check("rst_mbx",      32'(MBX),      0);
        check("rst_mby",      32'(MBY),      0);

        // Two macroblocks on one line at full rate
        xx_delay = 40;
        clear_logs();
        start_slice(8'd2, 8'd1, t);
        wait_done(400);
        check("t1_newline_count", 32'(nl_cyc.size()), 1);
        if (nl_cyc.size() > 0) begin
            check("t1_newline_time", nl_cyc[0], t + 2);
            check("t1_newslice_with_newline", 32'(ns_at_nl[0]), 1);
        end
        check("t1_strobe_count", 32'(strobe_cyc.size()), 64);
        check("t1_scoreboard_empty", 32'(exp_q.size()), 0);
        for (int k = 1; k < strobe_cyc.size(); k++)
            check("t1_strobe_gap", strobe_cyc[k] - strobe_cyc[k-1], (k % 16 == 0) ? 2 : 1);
        check("t1_xxinc_count", 32'(xx_cyc.size()), 2);
        if (xx_cyc.size() >= 2 && done_cyc.size() > 0)
            check("t1_done_after_2nd_xxinc", done_cyc[0], xx_cyc[1] + 2);
        check("t1_err", 32'(ERR), 0);
        check("t1_mbx_held", 32'(MBX), 1);
        check("t1_mby", 32'(MBY), 0);

        // READYI dropped for 5 cycles at word 20
        xx_delay = 5;
        clear_logs();
        start_slice(8'd1, 8'd1, t);
        wait_hs(20, 200);
        c = cyc;
        READYI = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK2);
            check("drop_srcready", 32'(SRCREADY), 0);
            if (i > 0) check("drop_strobei", 32'(STROBEI), 0);
            @(posedge CLK2); #1;
        end
        READYI = 1'b1;
        wait_done(300);
        check("t3_strobe_count", 32'(strobe_cyc.size()), 32);
        if (strobe_cyc.size() > 20) check("t3_word20_resume_time", strobe_cyc[20], c + 6);
        check("t3_scoreboard_empty", 32'(exp_q.size()), 0);

        // Two lines, one MB each, slow completion; START while busy must be ignored
        xx_delay = 40;
        clear_logs();
        start_slice(8'd1, 8'd2, t);
        wait_hs(10, 200);
        MBW   = 8'd5;
        MBH   = 8'd5;
        START = 1'b1;
        @(posedge CLK2); #1;
        START = 1'b0;
        wait_done(400);
        check("t4_newline_count", 32'(nl_cyc.size()), 2);
        check("t4_xxinc_count", 32'(xx_cyc.size()), 2);
        if (nl_cyc.size() >= 2 && xx_cyc.size() >= 1) begin
            check("t4_newline1_time", nl_cyc[0], t + 2);
            check("t4_newslice_line0", 32'(ns_at_nl[0]), 1);
            check("t4_newline2_after_xxinc", nl_cyc[1], xx_cyc[0] + 2);
            check("t4_newslice_line1", 32'(ns_at_nl[1]), 0);
            check("t4_mby_line1", 32'(mby_at_nl[1]), 1);
        end
        if (xx_cyc.size() >= 2 && done_cyc.size() > 0)
            check("t4_done_time", done_cyc[0], xx_cyc[1] + 2);
        check("t4_strobe_count", 32'(strobe_cyc.size()), 64);
        check("t4_mbx", 32'(MBX), 0);
        check("t4_mby", 32'(MBY), 1);
        check("t4_err", 32'(ERR), 0);

        // Empty slice, with a START during FIN that must be ignored
        clear_logs();
        @(posedge CLK2); #1;
        MBW   = 8'd0;
        MBH   = 8'd3;
        START = 1'b1;
        t     = cyc;
        @(posedge CLK2); #1;
        MBW = 8'd1;
        MBH = 8'd1;
        @(negedge CLK2);
        check("t5_busy_in_fin", 32'(BUSY), 1);
        @(posedge CLK2); #1;
        START = 1'b0;
        repeat (10) begin
            @(posedge CLK2); #1;
        end
        check("t5_done_count", 32'(done_cyc.size()), 1);
        if (done_cyc.size() > 0) check("t5_done_time", done_cyc[0], t + 2);
        check("t5_no_newline", 32'(nl_cyc.size()), 0);
        check("t5_no_strobe", 32'(strobe_cyc.size()), 0);
        check("t5_idle", 32'(BUSY), 0);

        // Completion pulse while nothing is in flight
        @(negedge CLK2);
        inject_xx = 1'b1;
        @(negedge CLK2);
        inject_xx = 1'b0;
        @(negedge CLK2);
        check("t6_err_set", 32'(ERR), 1);
        repeat (10) @(negedge CLK2);
        check("t6_err_sticky", 32'(ERR), 1);

        // Three MBs with completions held back: overflow saturates and flags
        xx_delay = 120;
        clear_logs();
        start_slice(8'd3, 8'd1, t);
        @(negedge CLK2);
        check("t7_err_cleared_by_start", 32'(ERR), 0);
        @(posedge CLK2); #1;
        wait_done(600);
        check("t7_strobe_count", 32'(strobe_cyc.size()), 96);
        check("t7_err_overflow", 32'(ERR), 1);
        if (xx_cyc.size() >= 2 && done_cyc.size() > 0)
            check("t7_done_after_2nd_xxinc", done_cyc[0], xx_cyc[1] + 2);
        begin
            int g = 0;
            while (xx_cyc.size() < 3 && g < 200) begin
                @(posedge CLK2); #1;
                g++;
            end
        end
        check("t7_third_xxinc", 32'(xx_cyc.size()), 3);

        // Reset in the middle of a load
        xx_delay = 40;
        clear_logs();
        start_slice(8'd1, 8'd1, t);
        wait_hs(10, 200);
        RST_N = 1'b1;
        @(posedge CLK2); #1;
        RST_N = 1'b0;
        @(negedge CLK2);
        check("mid_rst_srcready", 32'(SRCREADY), 0);
        check("mid_rst_newslice", 32'(NEWSLICE), 0);
        check("mid_rst_newline",  32'(NEWLINE),  0);
        check("mid_rst_strobei",  32'(STROBEI),  0);
        check("mid_rst_busy",     32'(BUSY),     0);
        check("mid_rst_done",     32'(DONE),     0);
        check("mid_rst_err",      32'(ERR),      0);
        check("mid_rst_datai",    DATAI,         0);
        check("mid_rst_mbx",      32'(MBX),      0);
        check("mid_rst_mby",      32'(MBY),      0);
        clear_logs();
        repeat (5) begin
            @(posedge CLK2); #1;
        end
        check("post_rst_no_strobe", 32'(strobe_cyc.size()), 0);
        check("post_rst_no_newline", 32'(nl_cyc.size()), 0);
        check("post_rst_idle", 32'(BUSY), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
